sram_driver: RTL

Synchronous initiator for the 8K x 8 asynchronous static RAM: converts single-beat read/write requests on a valid/ready interface into correctly sequenced SRAM pin activity (chip enables, write strobe, output enable, tristated data bus). It sits between on-chip logic and the SRAM pins. Access timing is met by counting clock cycles, sized for the RAM's 200 ns access/write delay.

---
 rtl/sram_driver.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sram_driver.sv
// -----------------------------------------------------------------------------
// sram_driver
//
// Synchronous initiator for an 8K x 8 asynchronous static RAM. Each accepted
// single-beat request on the valid/ready interface becomes a cycle-counted
// sequence on the SRAM pins:
//   write: SETUP (1) -> ACCESS (WAIT_CYCLES, n_we low) -> HOLD (1, rsp_valid)
//   read : SETUP (1, n_oe low) -> ACCESS (WAIT_CYCLES, n_oe low)
//          -> TURN (TURN_CYCLES, bus released, rsp_valid in first cycle)
// WAIT_CYCLES x clock period must exceed the RAM's 200 ns access/write time.
//
// Parameters
//   WAIT_CYCLES  strobe length in cycles (1..15)
//   TURN_CYCLES  idle cycles after a read before the next request (1..15)
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req_valid   request present
//   req_ready   driver idle and able to accept (high only in IDLE)
//   req_write   1 = write, 0 = read
//   req_addr    word address
//   req_wdata   write data
//   rsp_valid   one-cycle completion pulse
//   rsp_rdata   last read data (updated at the end of each read's ACCESS)
//   sram_addr   RAM address pins (hold last value when idle)
//   sram_data   RAM data bus, driven only during a write's SETUP/ACCESS/HOLD
//   sram_n_ce1  active-low chip enable
//   sram_ce2    active-high chip enable
//   sram_n_we   active-low write strobe
//   sram_n_oe   active-low output enable
// -----------------------------------------------------------------------------
module sram_driver #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned TURN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [12:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [12:0] sram_addr,
    inout  wire  [7:0]  sram_data,
    output logic        sram_n_ce1,
    output logic        sram_ce2,
    output logic        sram_n_we,
    output logic        sram_n_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_TURN
    } state_t;

    // Counter reload values: the counter runs down to zero, so a phase of
    // N cycles starts at N-1.
    localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] TURN_FIRST = 4'(TURN_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic        cnt_zero;
    logic        write_q;
    logic [12:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        selected;
    logic        data_oe;

    assign cnt_zero = (cnt_q == 4'd0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (req_valid) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (cnt_zero) state_d = write_q ? S_HOLD : S_TURN;
            S_HOLD:   state_d = S_IDLE;
            S_TURN:   if (cnt_zero) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latch, phase counter and read-data capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 13'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            // The request is only sampled in IDLE; later changes on req_*
            // cannot disturb an operation in flight.
            if (state_q == S_IDLE && req_valid) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end

            unique case (state_q)
                S_SETUP:  cnt_q <= WAIT_LAST;
                // The final ACCESS cycle preloads the TURN length; a write
                // goes to HOLD instead and simply ignores it.
                S_ACCESS: cnt_q <= cnt_zero ? TURN_FIRST : cnt_q - 4'd1;
                S_TURN:   if (!cnt_zero) cnt_q <= cnt_q - 4'd1;
                default:  cnt_q <= cnt_q;
            endcase

            // n_oe has been low for WAIT_CYCLES+1 cycles by this edge, so the
            // RAM's output is settled.
            if (state_q == S_ACCESS && cnt_zero && !write_q) begin
                rdata_q <= sram_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output decode: pins derive only from registered state, never from req_*
    // -------------------------------------------------------------------------
    always_comb begin
        selected   = 1'b0;
        data_oe    = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        sram_n_we  = 1'b1;
        sram_n_oe  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_SETUP: begin
                selected  = 1'b1;
                data_oe   = write_q;
                sram_n_oe = write_q;
            end
            S_ACCESS: begin
                selected  = 1'b1;
                data_oe   = write_q;
                sram_n_we = !write_q;
                sram_n_oe = write_q;
            end
            S_HOLD: begin
                // Address and data stay valid past the rising edge of n_we.
                selected  = 1'b1;
                data_oe   = 1'b1;
                rsp_valid = 1'b1;
            end
            S_TURN: begin
                rsp_valid = (cnt_q == TURN_FIRST);
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
        sram_n_ce1 = !selected;
        sram_ce2   = selected;
    end

    // Only writes ever drive the bus, and n_oe is high in every write state,
    // so the driver and the RAM can never drive sram_data together.
    assign sram_data = data_oe ? wdata_q : 8'bz;
    assign sram_addr = addr_q;
    assign rsp_rdata = rdata_q;

endmodule
